sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO, the next generation of the team's basic wr_en/rd_en/full/empty FIFO.
- Adds configurable data width and depth, an occupancy count, and programmable almost_full / almost_empty thresholds.
- Adds overflow/underflow error reporting.
- Sits between a producer and a consumer in the same clock domain and is the DUT of the FIFO VIP.

---
 rtl/sync_fifo_param.sv | 117 +++++++++++
 tb/tb_sync_fifo_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds and error flags.
// Latency: dout is registered, so data appears 1 cycle after an accepted rd_en; all flags are registered.
// Backpressure: writes are rejected while full, reads while empty, and each rejection raises overflow/underflow.
// Optional build macro FIFO_ERR_STICKY_EN: overflow/underflow hold until err_clr; otherwise they pulse for one cycle.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_nxt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_evt;
    logic                  unf_evt;

    // Accept decisions use only registered flags, so no input reaches an output combinationally.
    assign wr_acc  = wr_en & ~full;
    assign rd_acc  = rd_en & ~empty;
    assign ovf_evt = wr_en & full;
    assign unf_evt = rd_en & empty;

    // Next occupancy: a simultaneous accepted read and write cancel out.
    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage array; deliberately not reset, and writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, count, read data and status flags; flags derive from next count so they track count exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            dout         <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            count        <= count_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(AF_THRESH));
            almost_empty <= (count_nxt <= CW'(AE_THRESH));
        end
    end

`ifdef FIFO_ERR_STICKY_EN
    // Sticky error flags: a new event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_evt | (overflow  & ~err_clr);
            underflow <= unf_evt | (underflow & ~err_clr);
        end
    end
`else
    // err_clr has no role when the flags are plain pulses.
    logic unused_err_clr;
    assign unused_err_clr = err_clr;

    // One-cycle error pulses, registered one cycle after the offending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_evt;
            underflow <= unf_evt;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at DEPTH=4, DATA_WIDTH=8, AF_THRESH=3, AE_THRESH=1.
// Each step drives inputs 1 ns after a rising edge and checks outputs 1 ns after the next edge.
// Expected values are hand-derived; error-flag expectations follow FIFO_ERR_STICKY_EN when defined.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int errors = 0;
    int checks = 0;

    sync_fifo_param #(
        .DATA_WIDTH(8),
        .DEPTH(4),
        .AF_THRESH(3),
        .AE_THRESH(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .din(din),
        .rd_en(rd_en),
        .dout(dout),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then wait until just after the sampling edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic clr);
        wr_en   = w;
        rd_en   = r;
        din     = d;
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles with both requests active.
        rst = 1'b1;
        cyc(1'b1, 1'b1, 8'hAA, 1'b0);
        cyc(1'b1, 1'b1, 8'hAA, 1'b0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
        rst = 1'b0;

        // Fill: thresholds at 1 (almost_empty edge), 3 (almost_full) and 4 (full).
        cyc(1'b1, 1'b0, 8'h11, 1'b0);
        chk("fill1_count", 32'(count), 32'd1);
        chk("fill1_empty", 32'(empty), 32'd0);
        chk("fill1_aempty", 32'(almost_empty), 32'd1);
        cyc(1'b1, 1'b0, 8'h22, 1'b0);
        chk("fill2_aempty", 32'(almost_empty), 32'd0);
        chk("fill2_afull", 32'(almost_full), 32'd0);
        cyc(1'b1, 1'b0, 8'h33, 1'b0);
        chk("fill3_afull", 32'(almost_full), 32'd1);
        chk("fill3_full", 32'(full), 32'd0);
        cyc(1'b1, 1'b0, 8'h44, 1'b0);
        chk("fill4_count", 32'(count), 32'd4);
        chk("fill4_full", 32'(full), 32'd1);

        // Overflow: write while full is rejected.
        cyc(1'b1, 1'b0, 8'h55, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
`ifdef FIFO_ERR_STICKY_EN
        chk("ovf_hold", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);
`else
        chk("ovf_pulse", 32'(overflow), 32'd0);
`endif

        // Drain: one-cycle read latency, no trace of the rejected 0x55.
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("rd1_dout", 32'(dout), 32'h11);
        chk("rd1_count", 32'(count), 32'd3);
        chk("rd1_full", 32'(full), 32'd0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("rd2_dout", 32'(dout), 32'h22);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("rd3_dout", 32'(dout), 32'h33);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("rd4_dout", 32'(dout), 32'h44);
        chk("rd4_empty", 32'(empty), 32'd1);
        chk("rd4_count", 32'(count), 32'd0);

        // Underflow: read while empty; dout holds.
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_dout", 32'(dout), 32'h44);
        chk("unf_count", 32'(count), 32'd0);
`ifdef FIFO_ERR_STICKY_EN
        cyc(1'b0, 1'b1, 8'h00, 1'b1);
        chk("unf_setwins", 32'(underflow), 32'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("unf_clr", 32'(underflow), 32'd0);
`else
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("unf_pulse", 32'(underflow), 32'd0);
`endif

        // Simultaneous read/write at count 2, crossing the pointer wrap.
        cyc(1'b1, 1'b0, 8'h01, 1'b0);
        cyc(1'b1, 1'b0, 8'h02, 1'b0);
        chk("sim_pre_count", 32'(count), 32'd2);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1, 8'(i + 3), 1'b0);
            chk($sformatf("sim%0d_dout", i), 32'(dout), 32'(i + 1));
            chk($sformatf("sim%0d_count", i), 32'(count), 32'd2);
        end

        // Simultaneous access while full: read wins, write rejected.
        cyc(1'b1, 1'b0, 8'h09, 1'b0);
        cyc(1'b1, 1'b0, 8'h0A, 1'b0);
        chk("sfull_full", 32'(full), 32'd1);
        cyc(1'b1, 1'b1, 8'hBB, 1'b0);
        chk("sfull_dout", 32'(dout), 32'h07);
        chk("sfull_count", 32'(count), 32'd3);
        chk("sfull_ovf", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("sfull_ovf_after", 32'(overflow), 32'd0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("sfull_rd1", 32'(dout), 32'h08);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("sfull_rd2", 32'(dout), 32'h09);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("sfull_rd3", 32'(dout), 32'h0A);
        chk("sfull_drained", 32'(count), 32'd0);

        // Simultaneous access while empty: write wins, no bypass to dout.
        cyc(1'b1, 1'b1, 8'hCC, 1'b0);
        chk("sempty_count", 32'(count), 32'd1);
        chk("sempty_unf", 32'(underflow), 32'd1);
        chk("sempty_dout", 32'(dout), 32'h0A);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("sempty_unf_after", 32'(underflow), 32'd0);

        // Reset mid-operation at count 3 with a write pending.
        cyc(1'b1, 1'b0, 8'hD1, 1'b0);
        cyc(1'b1, 1'b0, 8'hD2, 1'b0);
        chk("mid_pre_count", 32'(count), 32'd3);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 8'hEE, 1'b0);
        rst = 1'b0;
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_dout", 32'(dout), 32'h00);
        cyc(1'b1, 1'b0, 8'h5A, 1'b0);
        chk("mid_wr_count", 32'(count), 32'd1);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("mid_rd_dout", 32'(dout), 32'h5A);
        chk("mid_rd_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
